// File: rtl/irq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : irq_ctrl
//  Description : Responder-side interrupt controller for the RISC5 interrupt
//                interface. Captures rising edges on NUM_IRQ device lines
//                into a pending register and picks the lowest-numbered
//                enabled pending line. It raises the CPU irq input, then
//                tracks the intack/rti/abort handshake. A small register
//                block on the CPU IO bus gives access to pend, enable,
//                in-service status, software trigger and raw lines.
//  Revision    : 1.0  initial release
// ============================================================================
module irq_ctrl #(
   parameter int NUM_IRQ = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_IRQ-1:0] irq_in,
   output logic               irq,
   input  logic               intack,
   input  logic               rti,
   input  logic               abort,
   input  logic               io_sel,
   input  logic [1:0]         io_adr,
   input  logic               rd,
   input  logic               wr,
   input  logic [31:0]        wdata,
   output logic [31:0]        rdata
);

   localparam int c_PAD_W = 32 - NUM_IRQ;

   localparam logic [1:0] c_ADR_PEND = 2'd0;
   localparam logic [1:0] c_ADR_ENB  = 2'd1;
   localparam logic [1:0] c_ADR_ISR  = 2'd2;
   localparam logic [1:0] c_ADR_RAW  = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_REQ     = 2'd1,
      S_SERVICE = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;

   logic [NUM_IRQ-1:0]   r_prev;
   logic [NUM_IRQ-1:0]   r_pend;
   logic [NUM_IRQ-1:0]   r_enb;
   logic                 r_isv;
   logic [3:0]           r_isn;
   logic [3:0]           r_req_num;
   logic                 r_irq;

   logic                 w_wr_pend;
   logic                 w_wr_enb;
   logic                 w_wr_isr;
   logic [NUM_IRQ-1:0]   w_ev;
   logic [NUM_IRQ-1:0]   w_swset;
   logic [NUM_IRQ-1:0]   w_w1c;
   logic [NUM_IRQ-1:0]   w_ack_clr;
   logic [NUM_IRQ-1:0]   w_pend_nxt;
   logic [NUM_IRQ-1:0]   w_act;
   logic                 w_any;
   logic [3:0]           w_sel;
   logic                 w_load_req;
   logic                 w_take;
   logic                 w_ret;

   // Upper write-data bits have no destination in this block.
   logic w_unused_ok;
   assign w_unused_ok = &{1'b0, wdata};

   // Bus write decode and the per-line event/set/clear vectors.
   always_comb begin
      w_wr_pend = io_sel & wr & (io_adr == c_ADR_PEND);
      w_wr_enb  = io_sel & wr & (io_adr == c_ADR_ENB);
      w_wr_isr  = io_sel & wr & (io_adr == c_ADR_ISR);
      w_ev      = irq_in & ~r_prev;
      w_swset   = w_wr_isr  ? wdata[NUM_IRQ-1:0] : '0;
      w_w1c     = w_wr_pend ? wdata[NUM_IRQ-1:0] : '0;
   end

   // Acknowledge clears exactly the line that was latched for this request.
   always_comb begin
      w_ack_clr = '0;
      for (int i = 0; i < NUM_IRQ; i++) begin
         w_ack_clr[i] = w_take && (r_req_num == i[3:0]);
      end
   end

   // Next pend: any set source wins over a same-cycle clear.
   always_comb begin
      w_pend_nxt = (r_pend & ~(w_w1c | w_ack_clr)) | w_ev | w_swset;
   end

   // Fixed-priority select: lowest enabled pending index wins.
   always_comb begin
      w_act = r_pend & r_enb;
      w_any = |w_act;
      w_sel = 4'd0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (w_act[i]) begin
            w_sel = i[3:0];
         end
      end
   end

   // Handshake FSM next-state and strobes.
   always_comb begin
      w_state_nxt = r_state;
      w_load_req  = 1'b0;
      w_take      = 1'b0;
      w_ret       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_any) begin
               w_load_req  = 1'b1;
               w_state_nxt = S_REQ;
            end
         end
         S_REQ: begin
            if (intack) begin
               w_take      = 1'b1;
               w_state_nxt = S_SERVICE;
            end
         end
         S_SERVICE: begin
            // rti and abort both end the service; together they act once.
            if (rti | abort) begin
               w_ret       = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Registered irq: high only while the FSM stays in REQ, which gives one
   // cycle between entering REQ and the CPU seeing the rising edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_irq <= 1'b0;
      end else begin
         r_irq <= (r_state == S_REQ) && (w_state_nxt == S_REQ);
      end
   end

   // Edge history, pending and enable registers. Lines already high at reset
   // are absorbed into the history so they do not look like events.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_prev <= irq_in;
         r_pend <= '0;
         r_enb  <= '0;
      end else begin
         r_prev <= irq_in;
         r_pend <= w_pend_nxt;
         if (w_wr_enb) begin
            r_enb <= wdata[NUM_IRQ-1:0];
         end
      end
   end

   // Latched request number and in-service status. The request number is
   // frozen once in REQ so later mask or pend changes cannot retarget it.
   // Leaving service clears the whole ISR view so it reads as idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_req_num <= 4'd0;
         r_isv     <= 1'b0;
         r_isn     <= 4'd0;
      end else begin
         if (w_load_req) begin
            r_req_num <= w_sel;
         end
         if (w_take) begin
            r_isv <= 1'b1;
            r_isn <= r_req_num;
         end else if (w_ret) begin
            r_isv <= 1'b0;
            r_isn <= 4'd0;
         end
      end
   end

   // Combinational read mux; the CPU consumes data in the rd cycle itself.
   always_comb begin
      rdata = 32'd0;
      if (io_sel & rd) begin
         case (io_adr)
            c_ADR_PEND: rdata = {{c_PAD_W{1'b0}}, r_pend};
            c_ADR_ENB:  rdata = {{c_PAD_W{1'b0}}, r_enb};
            c_ADR_ISR:  rdata = {r_isv, 27'd0, r_isn};
            c_ADR_RAW:  rdata = {{c_PAD_W{1'b0}}, irq_in};
            default:    rdata = 32'd0;
         endcase
      end
   end

   assign irq = r_irq;

endmodule
`default_nettype wire
